// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver (and a future transmitter).
// Contents: receive FSM state enum, parity-mode encodings, parity-enable helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    WAIT_HI = 3'd5
  } rx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // 2'b11 is treated as "no parity", same as PAR_NONE.
  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud tick generator: one-clock tick every baud_div+1 clocks.
// Ports: clk, reset (sync, active-high), baud_div (divider minus one), tick (registered).
module uart_baud_tick #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] baud_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Wrap with >= so a divider lowered below the current count recovers at once.
  always_comb begin
    cnt_d  = cnt_q + DIV_W'(1);
    tick_d = 1'b0;
    if (cnt_q >= baud_div) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with ready/valid output and error pulses.
// Ports: clk, reset (sync, active-high), Rx_EN, RxD (async line), baud_div,
//        parity_mode, stop_bits -> Rx_DATA/Rx_VALID (held, Rx_READY handshake),
//        Rx_PERROR/Rx_FERROR/Rx_OERROR/Rx_BREAK (1-cycle pulses).
// Build option: define UART_RX_MAJORITY_EN for 2-of-3 voting around mid-bit;
// otherwise a single sample is taken at sub-tick OVS/2.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OVS    = 16,
  parameter int unsigned DIV_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Rx_EN,
  input  logic              RxD,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [1:0]        parity_mode,
  input  logic              stop_bits,
  output logic [DATA_W-1:0] Rx_DATA,
  output logic              Rx_VALID,
  input  logic              Rx_READY,
  output logic              Rx_PERROR,
  output logic              Rx_FERROR,
  output logic              Rx_OERROR,
  output logic              Rx_BREAK
);

  localparam int unsigned SUB_W = $clog2(OVS);
  localparam int unsigned BIT_W = $clog2(DATA_W);

  rx_state_e         state_q, state_d;
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shf_q, shf_d;
  logic              par_q, par_d;
  logic              stop2_q, stop2_d;   // first of two stop bits already sampled
  logic              sbad_q, sbad_d;     // first of two stop bits was 0
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              oerr_q, oerr_d;
  logic              brk_q, brk_d;
  logic              rx_meta_q, rxs_q;
  logic              tick;
  logic              samp_en_c, samp_c;
  logic              bit_end_c, par_en_c, exp_par_c;
  logic              stop_bad_c, brk_c, par_bad_c;

  uart_baud_tick #(.DIV_W(DIV_W)) u_baud (
    .clk      (clk),
    .reset    (reset),
    .baud_div (baud_div),
    .tick     (tick)
  );

  // Two-flop synchroniser; resets to the idle-high level.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= RxD;
      rxs_q     <= rx_meta_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Collect votes at OVS/2-1 and OVS/2; decide with the live sample at OVS/2+1.
  logic [1:0] vote_q, vote_d;

  always_comb begin
    vote_d = vote_q;
    if (tick && (sub_q == SUB_W'(OVS/2 - 1))) vote_d[0] = rxs_q;
    if (tick && (sub_q == SUB_W'(OVS/2)))     vote_d[1] = rxs_q;
  end

  always_ff @(posedge clk) begin
    if (reset) vote_q <= 2'b11;
    else       vote_q <= vote_d;
  end

  assign samp_en_c = tick && (sub_q == SUB_W'(OVS/2 + 1));
  assign samp_c    = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxs_q) | (vote_q[1] & rxs_q);
`else
  assign samp_en_c = tick && (sub_q == SUB_W'(OVS/2));
  assign samp_c    = rxs_q;
`endif

  assign bit_end_c  = tick && (sub_q == SUB_W'(OVS - 1));
  assign par_en_c   = par_enabled(parity_mode);
  assign exp_par_c  = (parity_mode == PAR_EVEN) ? ^shf_q : ~^shf_q;
  // Frame verdict terms, meaningful only on the last stop-bit sample.
  assign stop_bad_c = sbad_q | ~samp_c;
  assign brk_c      = (shf_q == '0) && (!par_en_c || !par_q) && !samp_c && (!stop_bits || sbad_q);
  assign par_bad_c  = par_en_c && (par_q != exp_par_c);

  // Next-state, datapath and output-pulse logic.
  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    bit_d   = bit_q;
    shf_d   = shf_q;
    par_d   = par_q;
    stop2_d = stop2_q;
    sbad_d  = sbad_q;
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    oerr_d  = 1'b0;
    brk_d   = 1'b0;

    if (valid_q && Rx_READY) valid_d = 1'b0;

    if (!Rx_EN) begin
      state_d = IDLE;
      sub_d   = '0;
    end else begin
      if (tick && (state_q inside {START, DATA, PARITY, STOP}))
        sub_d = (sub_q == SUB_W'(OVS - 1)) ? '0 : sub_q + SUB_W'(1);

      case (state_q)
        IDLE: begin
          if (tick && !rxs_q) begin
            state_d = START;
            sub_d   = '0;
            bit_d   = '0;
            stop2_d = 1'b0;
            sbad_d  = 1'b0;
          end
        end
        START: begin
          if (samp_en_c && samp_c) begin
            state_d = IDLE;        // false start
            sub_d   = '0;
          end else if (bit_end_c) begin
            state_d = DATA;
          end
        end
        DATA: begin
          if (samp_en_c) shf_d = {samp_c, shf_q[DATA_W-1:1]};
          if (bit_end_c) begin
            if (bit_q == BIT_W'(DATA_W - 1)) state_d = par_en_c ? PARITY : STOP;
            else                             bit_d   = bit_q + BIT_W'(1);
          end
        end
        PARITY: begin
          if (samp_en_c) par_d = samp_c;
          if (bit_end_c) state_d = STOP;
        end
        STOP: begin
          if (samp_en_c) begin
            if (stop_bits && !stop2_q) begin
              stop2_d = 1'b1;
              sbad_d  = ~samp_c;
            end else begin
              state_d = IDLE;
              sub_d   = '0;
              if (brk_c) begin
                brk_d   = 1'b1;
                ferr_d  = 1'b1;
                state_d = WAIT_HI;
              end else if (stop_bad_c) begin
                ferr_d = 1'b1;
              end else if (par_bad_c) begin
                perr_d = 1'b1;
              end else if (valid_q && !Rx_READY) begin
                oerr_d = 1'b1;
              end else begin
                data_d  = shf_q;
                valid_d = 1'b1;
              end
            end
          end
        end
        WAIT_HI: begin
          if (tick && rxs_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sub_q   <= '0;
      bit_q   <= '0;
      shf_q   <= '0;
      par_q   <= 1'b0;
      stop2_q <= 1'b0;
      sbad_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      bit_q   <= bit_d;
      shf_q   <= shf_d;
      par_q   <= par_d;
      stop2_q <= stop2_d;
      sbad_q  <= sbad_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      oerr_q  <= oerr_d;
      brk_q   <= brk_d;
    end
  end

  assign Rx_DATA   = data_q;
  assign Rx_VALID  = valid_q;
  assign Rx_PERROR = perr_q;
  assign Rx_FERROR = ferr_q;
  assign Rx_OERROR = oerr_q;
  assign Rx_BREAK  = brk_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param (defaults, baud_div=0 -> 16 clocks/bit).
module tb_uart_rx_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        Rx_EN;
  logic        RxD;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        stop_bits;
  logic [7:0]  Rx_DATA;
  logic        Rx_VALID;
  logic        Rx_READY;
  logic        Rx_PERROR, Rx_FERROR, Rx_OERROR, Rx_BREAK;

  uart_rx_param dut (
    .clk         (clk),
    .reset       (reset),
    .Rx_EN       (Rx_EN),
    .RxD         (RxD),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .stop_bits   (stop_bits),
    .Rx_DATA     (Rx_DATA),
    .Rx_VALID    (Rx_VALID),
    .Rx_READY    (Rx_READY),
    .Rx_PERROR   (Rx_PERROR),
    .Rx_FERROR   (Rx_FERROR),
    .Rx_OERROR   (Rx_OERROR),
    .Rx_BREAK    (Rx_BREAK)
  );

  always #5 clk = ~clk;

  // High-cycle counters per error output; a clean single pulse adds exactly 1.
  int cnt_p = 0, cnt_f = 0, cnt_o = 0, cnt_b = 0;
  always @(negedge clk) begin
    cnt_p <= cnt_p + int'(Rx_PERROR);
    cnt_f <= cnt_f + int'(Rx_FERROR);
    cnt_o <= cnt_o + int'(Rx_OERROR);
    cnt_b <= cnt_b + int'(Rx_BREAK);
  end

  int n_checks = 0;
  int n_fail   = 0;
  int sp, sf, so, sb;

  typedef struct {
    logic [7:0] data;
    logic [1:0] pmode;
    logic       sb;
    logic       flip;      // invert the correct parity bit
    logic       st0;
    logic       st1;
    logic [7:0] exp_data;
    logic       exp_valid;
    int         exp_p;
    int         exp_f;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    RxD = v;
    clocks(16);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic sbits,
                            input logic flip, input logic st0, input logic st1);
    logic p;
    parity_mode = pm;
    stop_bits   = sbits;
    p = ((pm == 2'b01) ? ^d : ~^d) ^ flip;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (pm == 2'b01 || pm == 2'b10) send_bit(p);
    send_bit(st0);
    if (sbits) send_bit(st1);
    RxD = 1'b1;
  endtask

  task automatic snap();
    sp = cnt_p; sf = cnt_f; so = cnt_o; sb = cnt_b;
  endtask

  task automatic check_pulses(input string tag, input int ep, input int ef, input int eo, input int eb);
    check({tag, " perr"}, 32'(cnt_p - sp), 32'(ep));
    check({tag, " ferr"}, 32'(cnt_f - sf), 32'(ef));
    check({tag, " oerr"}, 32'(cnt_o - so), 32'(eo));
    check({tag, " brk"},  32'(cnt_b - sb), 32'(eb));
  endtask

  task automatic accept(input string tag);
    Rx_READY = 1'b1;
    clocks(1);
    Rx_READY = 1'b0;
    check({tag, " valid clears"}, 32'(Rx_VALID), 32'd0);
  endtask

  initial begin
    //            data   pm    sb    flip  st0   st1   exp    v     p  f
    vecs[0] = '{8'hA5, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 0, 0};
    vecs[1] = '{8'h3C, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1, 0};
    vecs[2] = '{8'h3C, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 0, 0};
    vecs[3] = '{8'h5A, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 0, 1};
    vecs[4] = '{8'hC3, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b1, 0, 0};
    vecs[5] = '{8'h96, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC3, 1'b0, 0, 1};
    vecs[6] = '{8'h7E, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 8'h7E, 1'b1, 0, 0};
    vecs[7] = '{8'h01, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 8'h7E, 1'b0, 1, 0};
    vecs[8] = '{8'h44, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 8'h7E, 1'b0, 0, 1};

    reset = 1'b1; Rx_EN = 1'b1; RxD = 1'b1; baud_div = 16'd0;
    parity_mode = 2'b00; stop_bits = 1'b0; Rx_READY = 1'b0;
    clocks(4);
    check("reset data",  32'(Rx_DATA),   32'd0);
    check("reset valid", 32'(Rx_VALID),  32'd0);
    check("reset perr",  32'(Rx_PERROR), 32'd0);
    check("reset ferr",  32'(Rx_FERROR), 32'd0);
    check("reset oerr",  32'(Rx_OERROR), 32'd0);
    check("reset brk",   32'(Rx_BREAK),  32'd0);
    reset = 1'b0;
    clocks(20);

    // Single-frame vectors: data/parity/stop combinations and error priority.
    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("v%0d", i);
      snap();
      send_frame(vecs[i].data, vecs[i].pmode, vecs[i].sb, vecs[i].flip, vecs[i].st0, vecs[i].st1);
      clocks(40);
      check({tag, " data"},  32'(Rx_DATA),  32'(vecs[i].exp_data));
      check({tag, " valid"}, 32'(Rx_VALID), 32'(vecs[i].exp_valid));
      check_pulses(tag, vecs[i].exp_p, vecs[i].exp_f, 0, 0);
      if (vecs[i].exp_valid) begin
        if (i == 0) begin
          clocks(50);
          check("v0 valid held", 32'(Rx_VALID), 32'd1);
        end
        accept(tag);
      end
    end

    // Overrun: two good frames back-to-back with no consumer.
    snap();
    send_frame(8'h12, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(8'h34, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    clocks(40);
    check("ovr data",  32'(Rx_DATA),  32'h12);
    check("ovr valid", 32'(Rx_VALID), 32'd1);
    check_pulses("ovr", 0, 0, 1, 0);
    accept("ovr");

    // Glitch: 4-clock low pulse is rejected as a false start.
    snap();
    RxD = 1'b0; clocks(4); RxD = 1'b1;
    clocks(60);
    check("glitch valid", 32'(Rx_VALID), 32'd0);
    check("glitch data",  32'(Rx_DATA),  32'h12);
    check_pulses("glitch", 0, 0, 0, 0);

    // Break: 12 bit times low, then a normal frame.
    snap();
    parity_mode = 2'b00; stop_bits = 1'b0;
    RxD = 1'b0; clocks(12 * 16); RxD = 1'b1;
    clocks(40);
    check("brk valid", 32'(Rx_VALID), 32'd0);
    check("brk data",  32'(Rx_DATA),  32'h12);
    check_pulses("brk", 0, 1, 0, 1);
    snap();
    send_frame(8'h81, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    clocks(40);
    check("post-brk data",  32'(Rx_DATA),  32'h81);
    check("post-brk valid", 32'(Rx_VALID), 32'd1);
    check_pulses("post-brk", 0, 0, 0, 0);

    // Reset in the middle of 0xFF (bit 4), remaining bits high.
    snap();
    RxD = 1'b0; clocks(16);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    reset = 1'b1; clocks(1); reset = 1'b0;
    RxD = 1'b1; clocks(6 * 16);
    check("rst-mid data",  32'(Rx_DATA),  32'd0);
    check("rst-mid valid", 32'(Rx_VALID), 32'd0);
    check_pulses("rst-mid", 0, 0, 0, 0);
    snap();
    send_frame(8'h0F, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    clocks(40);
    check("post-rst data",  32'(Rx_DATA),  32'h0F);
    check("post-rst valid", 32'(Rx_VALID), 32'd1);
    accept("post-rst");

    // Rx_EN dropped at bit 4 of 0xFF discards the frame.
    snap();
    RxD = 1'b0; clocks(16);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    Rx_EN = 1'b0; clocks(3); Rx_EN = 1'b1;
    RxD = 1'b1; clocks(6 * 16);
    check("dis-mid data",  32'(Rx_DATA),  32'h0F);
    check("dis-mid valid", 32'(Rx_VALID), 32'd0);
    check_pulses("dis-mid", 0, 0, 0, 0);
    send_frame(8'hE7, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    clocks(40);
    check("post-dis data",  32'(Rx_DATA),  32'hE7);
    check("post-dis valid", 32'(Rx_VALID), 32'd1);
    accept("post-dis");

`ifdef UART_RX_MAJORITY_EN
    // Majority build: a 1-clock low inside each '1' data bit of 0x55 is voted out.
    snap();
    parity_mode = 2'b00; stop_bits = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        RxD = 1'b1; clocks(8); RxD = 1'b0; clocks(1); RxD = 1'b1; clocks(7);
      end else begin
        send_bit(1'b0);
      end
    end
    send_bit(1'b1);
    clocks(40);
    check("maj data",  32'(Rx_DATA),  32'h55);
    check("maj valid", 32'(Rx_VALID), 32'd1);
    check_pulses("maj", 0, 0, 0, 0);
    accept("maj");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
